seq_calc_pipe: RTL and testbench

//  Pipelined, parametrised signed calculator. Successor to the 4-bit combinational calculator:

---
 rtl/seq_calc_pipe.sv | 146 ++++++++++++++
 tb/tb_seq_calc_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_calc_pipe.sv
// Two-stage signed calculator: S1 captures operands, S2 computes and holds the result.
// acc_sel selects the accumulator as operand A at compute time, so back-to-back beats can chain.
module seq_calc_pipe #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         acc_sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         clr_sticky
);

  localparam logic [W-1:0] ONE = W'(1);

  logic         s1_valid_q,   s1_valid_d;
  logic [2:0]   s1_op_q,      s1_op_d;
  logic [W-1:0] s1_a_q,       s1_a_d;
  logic [W-1:0] s1_b_q,       s1_b_d;
  logic         s1_acc_sel_q, s1_acc_sel_d;
  logic         out_valid_q,  out_valid_d;
  logic [W-1:0] r_q,          r_d;
  logic         ovf_q,        ovf_d;
  logic [W-1:0] acc_q,        acc_d;
  logic         ovf_sticky_q, ovf_sticky_d;

  logic         s2_free;
  logic         s1_adv;
  logic         in_fire;
  logic [W-1:0] opa;
  logic [W-1:0] res;
  logic         res_ovf;

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_fire  = in_valid && in_ready;

  // Operand A is taken from acc here, after the previous beat's S2 load has updated it.
  always_comb begin
    opa     = s1_acc_sel_q ? acc_q : s1_a_q;
    res     = '0;
    res_ovf = 1'b0;
    case (s1_op_q)
      3'b000, 3'b100: begin
        res     = opa + s1_b_q;
        res_ovf = (opa[W-1] == s1_b_q[W-1]) && (res[W-1] != opa[W-1]);
      end
      3'b001: begin
        res     = opa - s1_b_q;
        res_ovf = (opa[W-1] != s1_b_q[W-1]) && (res[W-1] != opa[W-1]);
      end
      3'b101: begin
        res     = s1_b_q - opa;
        res_ovf = (s1_b_q[W-1] != opa[W-1]) && (res[W-1] != s1_b_q[W-1]);
      end
      3'b010, 3'b011: begin
        res     = s1_b_q[W-1] ? (~s1_b_q + ONE) : s1_b_q;
        res_ovf = s1_b_q[W-1] && res[W-1];
      end
      default: begin
        res     = opa[W-1] ? (~opa + ONE) : opa;
        res_ovf = opa[W-1] && res[W-1];
      end
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_acc_sel_d = s1_acc_sel_q;
    if (in_fire) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = op;
      s1_a_d       = a;
      s1_b_d       = b;
      s1_acc_sel_d = acc_sel;
    end else if (s1_adv) begin
      s1_valid_d   = 1'b0;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    r_d          = r_q;
    ovf_d        = ovf_q;
    acc_d        = acc_q;
    ovf_sticky_d = ovf_sticky_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      r_d         = res;
      ovf_d       = res_ovf;
      acc_d       = res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A new overflow beats a simultaneous clear.
    if (s1_adv && res_ovf) begin
      ovf_sticky_d = 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_acc_sel_q <= 1'b0;
      out_valid_q  <= 1'b0;
      r_q          <= '0;
      ovf_q        <= 1'b0;
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_acc_sel_q <= s1_acc_sel_d;
      out_valid_q  <= out_valid_d;
      r_q          <= r_d;
      ovf_q        <= ovf_d;
      acc_q        <= acc_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign r          = r_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_seq_calc_pipe.sv
// Randomized self-checking bench for seq_calc_pipe (W=16) against an integer-arithmetic model.
module tb_seq_calc_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        acc_sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] r;
  logic        ovf;
  logic        ovf_sticky;
  logic        clr_sticky = 1'b0;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_acc_cyc = 0;

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          got_cyc[$];
  logic [15:0] model_acc = '0;
  logic        model_sticky = 1'b0;

  seq_calc_pipe #(.W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_sel(acc_sel),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .ovf(ovf),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({ovf, r});
      got_cyc.push_back(cyc);
    end
  end

  // Exact integer result, overflow = result outside the 16-bit signed range.
  function automatic logic [16:0] model_beat(input logic [2:0] o, input logic [15:0] av,
                                             input logic [15:0] bv, input logic s);
    int x, y, t;
    logic ov;
    x = s ? int'($signed(model_acc)) : int'($signed(av));
    y = int'($signed(bv));
    case (o)
      3'd0: t = x + y;
      3'd1: t = x - y;
      3'd2, 3'd3: t = (y < 0) ? -y : y;
      3'd4: t = y + x;
      3'd5: t = y - x;
      default: t = (x < 0) ? -x : x;
    endcase
    ov = (t > 32767) || (t < -32768);
    model_acc = t[15:0];
    if (ov) model_sticky = 1'b1;
    return {ov, t[15:0]};
  endfunction

  function automatic logic rdy(input int stall_pct);
    return $urandom_range(99) >= stall_pct;
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic send(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                      input logic s, input int stall_pct);
    int guard = 0;
    in_valid = 1'b1; op = o; a = av; b = bv; acc_sel = s;
    out_ready = rdy(stall_pct);
    #1;
    while (!in_ready) begin
      @(negedge clk);
      out_ready = rdy(stall_pct);
      #1;
      guard++;
      if (guard > 500) begin
        vectors++; errors++;
        $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(model_beat(o, av, bv, s));
    @(negedge clk);
    last_acc_cyc = cyc - 1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    rst = 1'b0;
    @(negedge clk); #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    vectors++; if (r !== 16'd0) begin errors++; $display("FAIL rst_r: got %0h want 0", r); end
    vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    vectors++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b want 0", ovf_sticky); end
  endtask

  task automatic test_basic();
    clear_queues();
    send(3'b000, 16'd100, -16'sd30, 1'b0, 0);
    out_ready = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    drain();
    vectors++;
    if (got_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== {1'b0, 16'd70}) begin errors++; $display("FAIL basic_r: got %0h want %0h", got_q[0], {1'b0, 16'd70}); end
      vectors++; if (got_cyc[0] - last_acc_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", got_cyc[0] - last_acc_cyc); end
    end
  endtask

  task automatic test_ovf_sticky();
    clear_queues();
    send(3'b000, 16'd32767, 16'd1, 1'b0, 0);
    drain();
    vectors++;
    if (got_q.size() != 1) begin errors++; $display("FAIL ovf_count: got %0d want 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== {1'b1, 16'h8000}) begin errors++; $display("FAIL ovf_r: got %0h want %0h", got_q[0], {1'b1, 16'h8000}); end
    end
    vectors++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b want 1", ovf_sticky); end
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    model_sticky = 1'b0;
    #1;
    vectors++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b want 0", ovf_sticky); end
  endtask

  task automatic test_abs_sub();
    logic [16:0] want [3];
    clear_queues();
    want[0] = {1'b1, 16'h8000};
    want[1] = {1'b0, 16'd5};
    want[2] = {1'b0, 16'hFFFC};
    send(3'b110, 16'h8000, 16'($urandom), 1'b0, 0);
    send(3'b010, 16'($urandom), -16'sd5, 1'b0, 0);
    send(3'b101, 16'd7, 16'd3, 1'b0, 0);
    drain();
    vectors++;
    if (got_q.size() != 3) begin errors++; $display("FAIL abs_count: got %0d want 3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got_q[i] !== want[i] || exp_q[i] !== want[i]) begin
        errors++; $display("FAIL abs_sub[%0d]: got %0h want %0h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    send(3'b000, 16'd1, 16'd1, 1'b0, 0);
    for (int i = 0; i < 3; i++) send(3'b000, 16'($urandom), 16'd1, 1'b1, 0);
    drain();
    vectors++;
    if (got_q.size() != 4) begin errors++; $display("FAIL chain_count: got %0d want 4", got_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_q[i] !== {1'b0, 16'(i + 2)}) begin
        errors++; $display("FAIL chain_r[%0d]: got %0h want %0h", i, got_q[i], i + 2);
      end
      if (i > 0) begin
        vectors++;
        if (got_cyc[i] - got_cyc[i-1] != 1) begin
          errors++; $display("FAIL chain_gap[%0d]: got %0d want 1", i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [2:0]  bo [6];
    logic [15:0] ba [6];
    logic [15:0] bb [6];
    logic [16:0] held;
    int sent = 0;
    clear_queues();
    for (int i = 0; i < 6; i++) begin
      bo[i] = 3'($urandom_range(5)); ba[i] = 16'($urandom); bb[i] = 16'($urandom);
    end
    held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = bo[sent]; a = ba[sent]; b = bb[sent]; acc_sel = 1'b0;
      #1;
      vectors++;
      if (in_ready !== (c < 2)) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want %b", c, in_ready, c < 2); end
      if (c == 2) begin
        held = {ovf, r};
        vectors++;
        if (held !== exp_q[0]) begin errors++; $display("FAIL stall_head: got %0h want %0h", held, exp_q[0]); end
      end else if (c > 2) begin
        vectors++;
        if ({ovf, r} !== held) begin errors++; $display("FAIL stall_hold[%0d]: got %0h want %0h", c, {ovf, r}, held); end
      end
      if (in_ready) begin
        exp_q.push_back(model_beat(bo[sent], ba[sent], bb[sent], 1'b0));
        sent++;
      end
      @(negedge clk);
    end
    while (sent < 6) begin
      send(bo[sent], ba[sent], bb[sent], 1'b0, 0);
      sent++;
    end
    drain();
    vectors++;
    if (got_q.size() != 6) begin errors++; $display("FAIL stall_count: got %0d want 6", got_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_order[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    clear_queues();
    for (int i = 0; i < 200; i++) begin
      send(3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 30);
      if ($urandom_range(3) == 0) begin
        out_ready = rdy(30);
        @(negedge clk);
      end
    end
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i] && bad < 10) begin
        bad++; errors++; $display("FAIL rand[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) errors++;
    end
    vectors++;
    if (ovf_sticky !== model_sticky) begin errors++; $display("FAIL rand_sticky: got %b want %b", ovf_sticky, model_sticky); end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b000; a = 16'd9; b = 16'd9; acc_sel = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: in_ready got %b want 0", in_ready); end
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_queues();
    model_acc = '0;
    model_sticky = 1'b0;
    send(3'b000, 16'($urandom), 16'd3, 1'b1, 0);
    drain();
    vectors++;
    if (got_q.size() != 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== {1'b0, 16'd3}) begin errors++; $display("FAIL mid_acc: got %0h want 3", got_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf_sticky();
    test_abs_sub();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

endmodule
